pcie_tx_arbiter: RTL and testbench

- Packet-atomic 2:1 arbiter that shares the PCIe core TX AXI-stream (64-bit) between two sources.
- Port 0 is the hardware PIO engine, which uses a req/ack handshake. Port 1 is the Ethernet inject path, which uses plain AXI-stream.
- It sits between both sources and the core's s_axis_tx, replacing direct wiring.
- It has a registered output skid stage and per-port packet counters for debug registers.

---
 rtl/pcie_tx_arb_pkg.sv | 26 ++
 rtl/axis_skid_buf.sv | 64 ++++++
 rtl/pcie_tx_arbiter.sv | 146 ++++++++++++++
 tb/tb_pcie_tx_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_tx_arb_pkg.sv
// Shared types for the PCIe TX arbiter: FSM states, the AXI-stream beat record
// carried through the skid stage, and a saturating counter helper.
package pcie_tx_arb_pkg;

  localparam int unsigned TUSER_W = 4;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned KEEP_W  = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    GRANT0,
    GRANT1
  } arb_state_t;

  typedef struct packed {
    logic              tlast;
    logic [KEEP_W-1:0] tkeep;
    logic [DATA_W-1:0] tdata;
    logic [TUSER_W-1:0] tuser;
  } axis_beat_t;

  function automatic logic [3:0] sat_inc(input logic [3:0] val, input logic [3:0] lim);
    return (val >= lim) ? lim : val + 4'd1;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-stream register slice. Input ready comes straight from a flop, so
// there is no combinational path from out_ready_i back to in_ready_o.
module axis_skid_buf
  import pcie_tx_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  axis_beat_t in_beat_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output axis_beat_t out_beat_o
);

  logic       out_valid_q, out_valid_d;
  logic       skid_valid_q, skid_valid_d;
  axis_beat_t out_beat_q, out_beat_d;
  axis_beat_t skid_beat_q, skid_beat_d;
  logic       push;

  assign in_ready_o  = ~skid_valid_q;
  assign push        = in_valid_i & ~skid_valid_q;
  assign out_valid_o = out_valid_q;
  assign out_beat_o  = out_beat_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    out_beat_d   = out_beat_q;
    skid_beat_d  = skid_beat_q;
    if (!out_valid_q || out_ready_i) begin
      // Output slot frees up: drain the skid entry first to keep beat order.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_beat_d   = skid_beat_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = push;
        if (push) begin
          out_beat_d = in_beat_i;
        end
      end
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_beat_d  = in_beat_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_beat_q   <= '0;
      skid_beat_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_beat_q   <= out_beat_d;
      skid_beat_q  <= skid_beat_d;
    end
  end

endmodule

// File: rtl/pcie_tx_arbiter.sv
// Packet-atomic 2:1 arbiter in front of the PCIe core TX stream: port 0 is the PIO
// engine (req/ack), port 1 the Ethernet inject path (plain AXI-stream).
module pcie_tx_arbiter
  import pcie_tx_arb_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH = 64,
  parameter int unsigned KEEP_WIDTH   = C_DATA_WIDTH / 8,
  parameter int unsigned PIO_PRIORITY = 0,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    pcie_clk,
  input  logic                    pcie_rst_n,
  input  logic                    p0_req,
  output logic                    p0_ack,
  output logic                    p0_tready,
  input  logic                    p0_tvalid,
  input  logic                    p0_tlast,
  input  logic [KEEP_WIDTH-1:0]   p0_tkeep,
  input  logic [C_DATA_WIDTH-1:0] p0_tdata,
  input  logic [TUSER_W-1:0]      p0_tuser,
  output logic                    p1_tready,
  input  logic                    p1_tvalid,
  input  logic                    p1_tlast,
  input  logic [KEEP_WIDTH-1:0]   p1_tkeep,
  input  logic [C_DATA_WIDTH-1:0] p1_tdata,
  input  logic [TUSER_W-1:0]      p1_tuser,
  input  logic                    m_tready,
  output logic                    m_tvalid,
  output logic                    m_tlast,
  output logic [KEEP_WIDTH-1:0]   m_tkeep,
  output logic [C_DATA_WIDTH-1:0] m_tdata,
  output logic [TUSER_W-1:0]      m_tuser,
  output logic [31:0]             pkt_cnt0,
  output logic [31:0]             pkt_cnt1,
  output logic                    busy
);

  localparam logic [3:0] StarveLim = 4'(STARVE_LIMIT);

  arb_state_t  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [3:0]  starve_q, starve_d;
  logic [31:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  logic        in_valid, in_ready;
  axis_beat_t  in_beat, out_beat;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    starve_d     = starve_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    in_valid     = 1'b0;
    in_beat      = '0;
    p0_tready    = 1'b0;
    p1_tready    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!p1_tvalid) begin
          starve_d = '0;
        end
        if (p0_req && p1_tvalid) begin
          if (PIO_PRIORITY == 0) begin
            state_d = last_grant_q ? GRANT0 : GRANT1;
          end else begin
            state_d = (starve_q == StarveLim) ? GRANT1 : GRANT0;
          end
        end else if (p0_req) begin
          state_d = GRANT0;
        end else if (p1_tvalid) begin
          state_d = GRANT1;
        end
      end
      GRANT0: begin
        p0_tready     = in_ready;
        in_valid      = p0_tvalid;
        in_beat.tlast = p0_tlast;
        in_beat.tkeep = p0_tkeep;
        in_beat.tdata = p0_tdata;
        in_beat.tuser = p0_tuser;
        if (p0_tvalid && in_ready && p0_tlast) begin
          state_d      = IDLE;
          last_grant_d = 1'b0;
          cnt0_d       = cnt0_q + 32'd1;
          // Count PIO wins only while the Ethernet path is actually waiting.
          if (p1_tvalid) begin
            starve_d = sat_inc(starve_q, StarveLim);
          end
        end
      end
      GRANT1: begin
        p1_tready     = in_ready;
        in_valid      = p1_tvalid;
        in_beat.tlast = p1_tlast;
        in_beat.tkeep = p1_tkeep;
        in_beat.tdata = p1_tdata;
        in_beat.tuser = p1_tuser;
        if (p1_tvalid && in_ready && p1_tlast) begin
          state_d      = IDLE;
          last_grant_d = 1'b1;
          cnt1_d       = cnt1_q + 32'd1;
          starve_d     = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      starve_q     <= '0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      starve_q     <= starve_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  axis_skid_buf u_skid (
    .clk_i       (pcie_clk),
    .rst_ni      (pcie_rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_beat_i   (in_beat),
    .out_valid_o (m_tvalid),
    .out_ready_i (m_tready),
    .out_beat_o  (out_beat)
  );

  assign m_tlast  = out_beat.tlast;
  assign m_tkeep  = out_beat.tkeep;
  assign m_tdata  = out_beat.tdata;
  assign m_tuser  = out_beat.tuser;
  assign p0_ack   = (state_q == GRANT0);
  assign busy     = (state_q != IDLE);
  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Bench for pcie_tx_arbiter: instance 0 round-robin, instance 1 PIO priority with
// STARVE_LIMIT=2. Beats are scoreboarded from input acceptance to output transfer.
module tb_pcie_tx_arbiter;

  localparam int DW = 64;
  localparam int KW = 8;

  typedef struct packed {
    logic          last;
    logic [KW-1:0] keep;
    logic [DW-1:0] data;
    logic [3:0]    user;
  } beat_t;

  typedef struct {
    int         inst;
    int         n0;
    int         n1;
    int         len;
    int         norder;
    logic [7:0] order;
  } scen_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n     [2];
  logic          p0_req    [2];
  logic          p0_ack    [2];
  logic          p0_tready [2];
  logic          p0_tvalid [2];
  logic          p0_tlast  [2];
  logic [KW-1:0] p0_tkeep  [2];
  logic [DW-1:0] p0_tdata  [2];
  logic [3:0]    p0_tuser  [2];
  logic          p1_tready [2];
  logic          p1_tvalid [2];
  logic          p1_tlast  [2];
  logic [KW-1:0] p1_tkeep  [2];
  logic [DW-1:0] p1_tdata  [2];
  logic [3:0]    p1_tuser  [2];
  logic          m_tready  [2];
  logic          m_tvalid  [2];
  logic          m_tlast   [2];
  logic [KW-1:0] m_tkeep   [2];
  logic [DW-1:0] m_tdata   [2];
  logic [3:0]    m_tuser   [2];
  logic [31:0]   cnt0      [2];
  logic [31:0]   cnt1      [2];
  logic          busy      [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pcie_tx_arbiter #(
      .C_DATA_WIDTH (DW),
      .PIO_PRIORITY (g),
      .STARVE_LIMIT ((g == 1) ? 2 : 4)
    ) u_dut (
      .pcie_clk   (clk),
      .pcie_rst_n (rst_n[g]),
      .p0_req     (p0_req[g]),
      .p0_ack     (p0_ack[g]),
      .p0_tready  (p0_tready[g]),
      .p0_tvalid  (p0_tvalid[g]),
      .p0_tlast   (p0_tlast[g]),
      .p0_tkeep   (p0_tkeep[g]),
      .p0_tdata   (p0_tdata[g]),
      .p0_tuser   (p0_tuser[g]),
      .p1_tready  (p1_tready[g]),
      .p1_tvalid  (p1_tvalid[g]),
      .p1_tlast   (p1_tlast[g]),
      .p1_tkeep   (p1_tkeep[g]),
      .p1_tdata   (p1_tdata[g]),
      .p1_tuser   (p1_tuser[g]),
      .m_tready   (m_tready[g]),
      .m_tvalid   (m_tvalid[g]),
      .m_tlast    (m_tlast[g]),
      .m_tkeep    (m_tkeep[g]),
      .m_tdata    (m_tdata[g]),
      .m_tuser    (m_tuser[g]),
      .pkt_cnt0   (cnt0[g]),
      .pkt_cnt1   (cnt1[g]),
      .busy       (busy[g])
    );
  end

  // Source model state, indexed [instance][port].
  int    tgt  [2][2];
  int    done [2][2];
  int    bidx [2][2];
  int    len  [2][2];
  bit    acc  [2][2];
  beat_t sb   [2][$];
  beat_t held [2];
  bit    stall[2];
  int    gport[2][16];
  int    gcnt [2];
  int    pass_cnt = 0;
  int    total_cnt = 0;
  scen_t tab[4];

  function automatic beat_t mk(int i, int p, int k, int b, int l);
    beat_t r;
    r.data = {4'(p), 4'(i), 24'(k), 32'((b + 1) * 17)};
    r.last = (b == l - 1);
    r.keep = r.last ? 8'h0F : 8'hFF;
    r.user = {1'(p), 3'(b)};
    return r;
  endfunction

  task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic drive(int i);
    beat_t b0, b1;
    bit    pend0, pend1;
    pend0 = rst_n[i] && (done[i][0] < tgt[i][0]);
    pend1 = rst_n[i] && (done[i][1] < tgt[i][1]);
    b0 = mk(i, 0, done[i][0], bidx[i][0], len[i][0]);
    b1 = mk(i, 1, done[i][1], bidx[i][1], len[i][1]);
    p0_req[i]    = pend0;
    p0_tvalid[i] = pend0 && (p0_ack[i] === 1'b1);
    {p0_tlast[i], p0_tkeep[i], p0_tdata[i], p0_tuser[i]} = b0;
    p1_tvalid[i] = pend1;
    {p1_tlast[i], p1_tkeep[i], p1_tdata[i], p1_tuser[i]} = b1;
  endtask

  // One clock: judge transfers at the falling edge, advance sources after the rise.
  task automatic step();
    beat_t cur, exp;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n[i]) begin
        sb[i].delete();
        stall[i] = 1'b0;
        for (int p = 0; p < 2; p++) begin
          acc[i][p]  = 1'b0;
          bidx[i][p] = 0;
        end
      end else begin
        acc[i][0] = p0_tvalid[i] && p0_tready[i];
        acc[i][1] = p1_tvalid[i] && p1_tready[i];
        for (int p = 0; p < 2; p++)
          if (acc[i][p]) sb[i].push_back(mk(i, p, done[i][p], bidx[i][p], len[i][p]));
        cur = {m_tlast[i], m_tkeep[i], m_tdata[i], m_tuser[i]};
        if (stall[i]) chk("stall_hold", {m_tvalid[i], cur}, {1'b1, held[i]});
        if (m_tvalid[i] && m_tready[i]) begin
          if (sb[i].size() == 0) chk("unexpected_beat", cur, 0);
          else begin
            exp = sb[i].pop_front();
            chk("beat", cur, exp);
          end
          if (m_tlast[i] && gcnt[i] < 16) begin
            gport[i][gcnt[i]] = int'(m_tdata[i][63:60]);
            gcnt[i]++;
          end
        end
        stall[i] = m_tvalid[i] && !m_tready[i];
        held[i]  = cur;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (acc[i][p]) begin
          if (bidx[i][p] == len[i][p] - 1) begin
            bidx[i][p] = 0;
            done[i][p]++;
          end else bidx[i][p]++;
        end
        acc[i][p] = 1'b0;
      end
      drive(i);
    end
  endtask

  task automatic run_until_done(int i, int budget);
    int n = 0;
    while ((done[i][0] < tgt[i][0] || done[i][1] < tgt[i][1] || sb[i].size() != 0)
           && n < budget) begin
      step();
      n++;
    end
    chk("timeout", 128'(n < budget), 1);
    step();
    step();
  endtask

  task automatic do_reset(int i);
    rst_n[i]    = 1'b0;
    m_tready[i] = 1'b1;
    tgt[i][0]   = done[i][0];
    tgt[i][1]   = done[i][1];
    step();
    step();
    rst_n[i] = 1'b1;
    gcnt[i]  = 0;
    step();
  endtask

  initial begin
    int n;
    tab[0] = '{inst: 0, n0: 2, n1: 2, len: 2, norder: 4, order: 8'b0000_1010};
    tab[1] = '{inst: 1, n0: 4, n1: 2, len: 1, norder: 6, order: 8'b0010_0100};
    tab[2] = '{inst: 0, n0: 0, n1: 2, len: 1, norder: 2, order: 8'b0000_0011};
    tab[3] = '{inst: 1, n0: 3, n1: 0, len: 3, norder: 3, order: 8'b0000_0000};

    for (int i = 0; i < 2; i++) begin
      rst_n[i]    = 1'b0;
      m_tready[i] = 1'b1;
      gcnt[i]     = 0;
      stall[i]    = 1'b0;
      for (int p = 0; p < 2; p++) begin
        tgt[i][p]  = 0;
        done[i][p] = 0;
        bidx[i][p] = 0;
        len[i][p]  = 1;
        acc[i][p]  = 1'b0;
      end
      drive(i);
    end
    step();
    step();
    for (int i = 0; i < 2; i++) begin
      chk("rst_m_tvalid", m_tvalid[i], 0);
      chk("rst_m_tdata", m_tdata[i], 0);
      chk("rst_p0_ack", p0_ack[i], 0);
      chk("rst_p0_tready", p0_tready[i], 0);
      chk("rst_p1_tready", p1_tready[i], 0);
      chk("rst_cnt0", cnt0[i], 0);
      chk("rst_cnt1", cnt1[i], 0);
      chk("rst_busy", busy[i], 0);
      rst_n[i] = 1'b1;
    end
    step();

    // Port 0 alone, 3 beats 0x11/0x22/0x33.
    len[0][0] = 3;
    tgt[0][0] = done[0][0] + 1;
    step();
    chk("req_up", p0_req[0], 1);
    chk("ack_not_yet", p0_ack[0], 0);
    step();
    chk("ack_one_cycle", p0_ack[0], 1);
    chk("first_data", p0_tdata[0], 64'h11);
    run_until_done(0, 40);
    chk("p0_cnt0", cnt0[0], 1);
    chk("p0_ack_after", p0_ack[0], 0);
    chk("p0_order", gport[0][0], 0);

    // Arbitration scenarios from the table.
    for (int s = 0; s < 4; s++) begin
      int i;
      i = tab[s].inst;
      do_reset(i);
      len[i][0] = tab[s].len;
      len[i][1] = tab[s].len;
      tgt[i][0] = done[i][0] + tab[s].n0;
      tgt[i][1] = done[i][1] + tab[s].n1;
      run_until_done(i, 200);
      chk($sformatf("s%0d_npkts", s), gcnt[i], tab[s].norder);
      for (int k = 0; k < tab[s].norder; k++)
        chk($sformatf("s%0d_order%0d", s, k), gport[i][k], 128'(tab[s].order[k]));
      chk($sformatf("s%0d_cnt0", s), cnt0[i], tab[s].n0);
      chk($sformatf("s%0d_cnt1", s), cnt1[i], tab[s].n1);
    end

    // Backpressure: 4-beat port 1 packet into a stalled output.
    do_reset(0);
    m_tready[0] = 1'b0;
    len[0][1]   = 4;
    tgt[0][1]   = done[0][1] + 1;
    for (int c = 0; c < 8; c++) step();
    chk("bp_absorbed", bidx[0][1], 2);
    chk("bp_tready", p1_tready[0], 0);
    chk("bp_m_tvalid", m_tvalid[0], 1);
    chk("bp_m_tdata", m_tdata[0], 64'h1000_0000_0000_0000 | 64'(done[0][1]) << 32 | 64'h11);
    m_tready[0] = 1'b1;
    run_until_done(0, 40);
    chk("bp_cnt1", cnt1[0], 1);
    chk("bp_npkts", gcnt[0], 1);

    // Mid-packet reset after beat 2 of a 4-beat port 0 packet.
    do_reset(0);
    len[0][1] = 1;
    tgt[0][1] = done[0][1] + 1;
    run_until_done(0, 40);
    chk("mr_cnt1_pre", cnt1[0], 1);
    len[0][0] = 4;
    tgt[0][0] = done[0][0] + 1;
    n = 0;
    while (bidx[0][0] != 2 && n < 40) begin
      step();
      n++;
    end
    chk("mr_timeout", 128'(n < 40), 1);
    rst_n[0] = 1'b0;
    #1;
    chk("mr_m_tvalid", m_tvalid[0], 0);
    chk("mr_p0_ack", p0_ack[0], 0);
    chk("mr_cnt0", cnt0[0], 0);
    chk("mr_cnt1", cnt1[0], 0);
    tgt[0][0] = done[0][0];
    step();
    step();
    rst_n[0] = 1'b1;
    gcnt[0]  = 0;
    step();
    len[0][0] = 1;
    len[0][1] = 1;
    tgt[0][0] = done[0][0] + 1;
    tgt[0][1] = done[0][1] + 1;
    run_until_done(0, 40);
    chk("mr_npkts", gcnt[0], 2);
    chk("mr_first_p0", gport[0][0], 0);
    chk("mr_second_p1", gport[0][1], 1);

    // Counter wrap on port 1.
    do_reset(1);
    force g_dut[1].u_dut.cnt1_q = 32'hFFFF_FFFF;
    step();
    release g_dut[1].u_dut.cnt1_q;
    step();
    chk("wrap_preload", cnt1[1], 32'hFFFF_FFFF);
    len[1][1] = 2;
    tgt[1][1] = done[1][1] + 1;
    run_until_done(1, 40);
    chk("wrap_cnt1", cnt1[1], 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
